cnn_frame_sequencer: RTL and testbench

// - Sequences whole camera frames into the CNN core (top) and returns one classified digit per frame.
// - Sits between the camera pixel stream and the CNN: it synchronises to frame boundaries, gates

---
 rtl/cnn_seq_pkg.sv | 13 +
 rtl/sat_counter.sv | 12 +
 rtl/cnn_frame_sequencer.sv | 92 +++++++++
 tb/tb_cnn_frame_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared state type and sizing helpers for the CNN frame sequencer
package cnn_seq_pkg;
  typedef enum logic [2:0] {IDLE, STREAM, WAIT_RES, HOLD, RECOVER} seq_state_t;
  function automatic int npix(input int dim);
    return dim * dim;
  endfunction
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous active-low reset counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= !rst ? '0 : (en && cnt != '1) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: gates whole camera frames into the CNN and returns one digit per frame
module cnn_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int IMG_DIM     = 30,
  parameter int PIX_W       = 8,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int RST_CYC     = 8,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eof_i,
  input  logic [PIX_W-1:0]   pix_i,
  input  logic               pix_i_valid,
  output logic [PIX_W-1:0]   cnn_pix_o,
  output logic               cnn_pix_o_valid,
  output logic               cnn_rst_n,
  input  logic [DIGIT_W-1:0] cnn_digit_i,
  input  logic               cnn_digit_i_valid,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               digit_o_valid,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic [CNT_W-1:0]   err_cnt_o
);
  localparam int NPIX = npix(IMG_DIM);
  localparam int PC_W = cnt_w(NPIX);
  localparam int WD_W = cnt_w(max2(TIMEOUT_CYC, RST_CYC));
  seq_state_t state, nxt;
  logic [PC_W-1:0] pix_cnt;
  logic [WD_W-1:0] wd;
  logic eof_pend, fwd, last, expire, got, short_frame, timed_out;
  assign fwd         = state == STREAM && pix_i_valid;
  assign last        = fwd && pix_cnt == PC_W'(NPIX - 1);
  assign expire      = wd == WD_W'(TIMEOUT_CYC - 1);
  assign got         = state == WAIT_RES && cnn_digit_i_valid;
  assign short_frame = state == STREAM && eof_i && !last;
  assign timed_out   = state == WAIT_RES && expire && !cnn_digit_i_valid;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = eof_i ? STREAM : IDLE;
      STREAM:   nxt = last ? WAIT_RES : eof_i ? RECOVER : STREAM;
      WAIT_RES: nxt = cnn_digit_i_valid ? HOLD : expire ? RECOVER : WAIT_RES;
      HOLD:     nxt = (eof_pend || eof_i) ? STREAM : HOLD;
      RECOVER:  nxt = wd == WD_W'(RST_CYC - 1) ? IDLE : RECOVER;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      wd              <= '0;
      eof_pend        <= 1'b0;
      cnn_pix_o       <= '0;
      cnn_pix_o_valid <= 1'b0;
      cnn_rst_n       <= 1'b0;
      digit_o         <= '0;
      digit_o_valid   <= 1'b0;
      busy_o          <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      state           <= nxt;
      pix_cnt         <= nxt != state ? '0 : pix_cnt + PC_W'(fwd);
      wd              <= nxt != state ? '0 : wd + WD_W'(state == WAIT_RES || state == RECOVER);
      eof_pend        <= (nxt == WAIT_RES || nxt == HOLD) && (eof_pend || eof_i);
      cnn_pix_o       <= fwd ? pix_i : cnn_pix_o;
      cnn_pix_o_valid <= fwd;
      cnn_rst_n       <= nxt != RECOVER;
      digit_o         <= got ? cnn_digit_i : digit_o;
      digit_o_valid   <= got;
      busy_o          <= nxt == STREAM || nxt == WAIT_RES;
      timeout_o       <= got ? 1'b0 : timed_out ? 1'b1 : timeout_o;
    end
  end
  sat_counter #(.W(CNT_W)) u_drop (
    .clk(clk),
    .rst(rst),
    .en (pix_i_valid && state != STREAM),
    .cnt(drop_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_err (
    .clk(clk),
    .rst(rst),
    .en (short_frame || timed_out),
    .cnt(err_cnt_o)
  );
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: scoreboard bench for frame gating, results, recovery and counters
module tb_cnn_frame_sequencer;
  logic       clk = 0;
  logic       rst = 0;
  logic       eof_i = 0;
  logic [7:0] pix_i = 0;
  logic       pix_i_valid = 0;
  logic [7:0] cnn_pix_o;
  logic       cnn_pix_o_valid;
  logic       cnn_rst_n;
  logic [3:0] cnn_digit_i = 0;
  logic       cnn_digit_i_valid = 0;
  logic [3:0] digit_o;
  logic       digit_o_valid;
  logic       busy_o;
  logic       timeout_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] err_cnt_o;
  typedef struct {
    logic [7:0] v;
    int         c;
  } pix_t;
  pix_t       pix_q[$];
  logic [3:0] dig_q[$];
  int         rec_q[$];
  pix_t       pe;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         run = 0;
  bit         seen_hi = 0;
  int         n;
  cnn_frame_sequencer #(
    .IMG_DIM(4), .PIX_W(8), .DIGIT_W(4), .TIMEOUT_CYC(50), .RST_CYC(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eof_i(eof_i),
    .pix_i(pix_i),
    .pix_i_valid(pix_i_valid),
    .cnn_pix_o(cnn_pix_o),
    .cnn_pix_o_valid(cnn_pix_o_valid),
    .cnn_rst_n(cnn_rst_n),
    .cnn_digit_i(cnn_digit_i),
    .cnn_digit_i_valid(cnn_digit_i_valid),
    .digit_o(digit_o),
    .digit_o_valid(digit_o_valid),
    .busy_o(busy_o),
    .timeout_o(timeout_o),
    .drop_cnt_o(drop_cnt_o),
    .err_cnt_o(err_cnt_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cnn_pix_o_valid) begin
      if (pix_q.size() == 0) check("pix_unexpected", cnn_pix_o_valid, 0);
      else begin
        pe = pix_q.pop_front();
        check("pix_value", cnn_pix_o, pe.v);
        check("pix_cycle", cyc, pe.c);
      end
    end
    if (digit_o_valid) begin
      if (dig_q.size() == 0) check("digit_unexpected", digit_o_valid, 0);
      else check("digit_value", digit_o, dig_q.pop_front());
    end
    if (!rst) begin
      seen_hi = 0;
      run = 0;
    end else if (cnn_rst_n) begin
      if (run > 0) begin
        if (rec_q.size() == 0) check("rst_low_unexpected", run, 0);
        else check("rst_low_cycles", run, rec_q.pop_front());
      end
      run = 0;
      seen_hi = 1;
    end else if (seen_hi) run++;
  end
  task automatic step(input logic e, input logic v, input logic [7:0] p, input logic dv, input logic [3:0] d);
    eof_i = e;
    pix_i_valid = v;
    pix_i = p;
    cnn_digit_i_valid = dv;
    cnn_digit_i = d;
    @(negedge clk);
    eof_i = 0;
    pix_i_valid = 0;
    cnn_digit_i_valid = 0;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic frame(input logic [7:0] base, input int cnt, input int nfwd);
    for (int i = 0; i < cnt; i++) begin
      if (i < nfwd) pix_q.push_back('{base + 8'(i), cyc + 1});
      step(0, 1, base + 8'(i), 0, 0);
    end
  endtask
  task automatic result(input logic [3:0] d);
    dig_q.push_back(d);
    step(0, 0, 0, 1, d);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=%0d required=%0d", cyc, 0);
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_cnn_rst_n", cnn_rst_n, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pix_valid", cnn_pix_o_valid, 0);
    check("rst_digit", digit_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_err", err_cnt_o, 0);
    rst = 1;
    idle(2);
    check("idle_cnn_rst_n", cnn_rst_n, 1);
    // good frame, result after 20 cycles
    step(1, 0, 0, 0, 0);
    check("stream_busy", busy_o, 1);
    frame(0, 16, 16);
    idle(19);
    result(7);
    idle(2);
    check("t1_digit", digit_o, 7);
    check("t1_drop", drop_cnt_o, 0);
    check("t1_hold_busy", busy_o, 0);
    // short frame
    step(1, 0, 0, 0, 0);
    frame(20, 10, 10);
    rec_q.push_back(4);
    step(1, 0, 0, 0, 0);
    idle(6);
    check("t2_err", err_cnt_o, 1);
    check("t2_busy", busy_o, 0);
    check("t2_cnn_rst_n", cnn_rst_n, 1);
    // timeout then recovery frame
    step(1, 0, 0, 0, 0);
    frame(40, 16, 16);
    rec_q.push_back(4);
    n = 0;
    while (!timeout_o && n < 200) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    check("t3_timeout_latency", n, 50);
    idle(6);
    check("t3_err", err_cnt_o, 2);
    check("t3_timeout_sticky", timeout_o, 1);
    step(1, 0, 0, 0, 0);
    frame(60, 16, 16);
    idle(5);
    result(3);
    idle(1);
    check("t3_digit", digit_o, 3);
    check("t3_timeout_clr", timeout_o, 0);
    // overflow and spurious result in HOLD
    step(1, 0, 0, 0, 0);
    frame(100, 20, 16);
    result(5);
    step(0, 0, 0, 1, 9);
    idle(2);
    check("t4_drop", drop_cnt_o, 4);
    check("t4_digit_held", digit_o, 5);
    // eof during WAIT_RES carries into the next frame
    step(1, 0, 0, 0, 0);
    frame(130, 16, 16);
    step(1, 0, 0, 0, 0);
    idle(3);
    result(2);
    idle(1);
    frame(150, 16, 16);
    idle(4);
    result(6);
    idle(2);
    check("t5_digit", digit_o, 6);
    check("t5_drop", drop_cnt_o, 4);
    check("t5_err", err_cnt_o, 2);
    // reset mid-frame
    step(1, 0, 0, 0, 0);
    frame(200, 8, 8);
    rst = 0;
    step(0, 1, 208, 0, 0);
    check("t6_pix_valid", cnn_pix_o_valid, 0);
    check("t6_digit", digit_o, 0);
    check("t6_drop", drop_cnt_o, 0);
    check("t6_err", err_cnt_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_cnn_rst_n", cnn_rst_n, 0);
    step(0, 0, 0, 0, 0);
    rst = 1;
    idle(2);
    step(1, 0, 0, 0, 0);
    frame(220, 16, 16);
    idle(10);
    result(8);
    idle(2);
    check("t6_new_digit", digit_o, 8);
    check("t6_new_drop", drop_cnt_o, 0);
    idle(3);
    check("pix_queue_left", pix_q.size(), 0);
    check("digit_queue_left", dig_q.size(), 0);
    check("recover_queue_left", rec_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
